// File: rtl/add_err_intr_ctrl_pkg.sv
// Shared opcode, state and width definitions for the ADD error/interrupt stage.
package err_pkg;

  // Default widths
  localparam int CNT_W_DEFAULT = 16;
  localparam int OP_W_DEFAULT  = 3;

  // Request opcodes seen on the datapath; only OP_ADD is accounted here
  localparam int OP_NOP = 0;
  localparam int OP_ADD = 1;
  localparam int OP_SUB = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;

  // Interrupt sequencing: ARM is the one-cycle delay before PEND
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PEND = 2'd2
  } intr_state_e;

endpackage

// File: rtl/add_err_intr_ctrl_if.sv
// Request/status bundle between the ECC checker side and the error stage.
interface add_err_intr_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int OP_W  = 3
);
  logic             req_valid;
  logic [OP_W-1:0]  req_op;
  logic             uncorr_err;
  logic             corr_err;
  logic             intr_mask;
  logic             intr_clr;
  logic             cnt_clr;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] corr_cnt;
  logic             interrupt;
  logic             intr_ovf;
  logic             cnt_sat;

  modport master (
    output req_valid, req_op, uncorr_err, corr_err, intr_mask, intr_clr, cnt_clr,
    input  err_cnt, corr_cnt, interrupt, intr_ovf, cnt_sat
  );

  modport slave (
    input  req_valid, req_op, uncorr_err, corr_err, intr_mask, intr_clr, cnt_clr,
    output err_cnt, corr_cnt, interrupt, intr_ovf, cnt_sat
  );
endinterface

// File: rtl/add_err_intr_ctrl_sat_counter.sv
// Saturating event counter. A clear coinciding with an increment yields 1 so
// the event is never lost. at_max flags that the value being loaded this
// cycle is the maximum, letting the caller set a sticky flag on the same edge.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  // Next value: clear (keeping a coincident event), else saturating increment
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = inc ? W'(1) : '0;
    end else if (inc && (count_reg != MAX_VAL)) begin
      count_next = count_reg + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count  = count_reg;
  assign at_max = (count_next == MAX_VAL);

endmodule

// File: rtl/add_err_intr_ctrl.sv
// Error accounting and interrupt generation for uncorrectable/correctable
// ECC errors on ADD requests.
module add_err_intr_ctrl
  import err_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int OP_W  = OP_W_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  add_err_intr_ctrl_if.slave  bus
);

  logic is_add;
  logic ue;
  logic ce;

  assign is_add = bus.req_valid & (bus.req_op == OP_W'(OP_ADD));
  assign ue     = is_add & bus.uncorr_err;
  // An uncorrectable error takes precedence; the request is not double-counted
  assign ce     = is_add & bus.corr_err & ~bus.uncorr_err;

  // Counter bank: index 0 uncorrectable, index 1 correctable
  logic [1:0]            inc_vec;
  logic [1:0]            at_max_vec;
  logic [1:0][CNT_W-1:0] cnt_arr;

  assign inc_vec = {ce, ue};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (inc_vec[gi]),
        .clr    (bus.cnt_clr),
        .count  (cnt_arr[gi]),
        .at_max (at_max_vec[gi])
      );
    end
  endgenerate

  assign bus.err_cnt  = cnt_arr[0];
  assign bus.corr_cnt = cnt_arr[1];

  intr_state_e state_reg, state_next;
  logic        ovf_reg, ovf_next;
  logic        sat_reg, sat_next;

  // Next-state, overflow and saturation flags
  always_comb begin
    state_next = state_reg;
    ovf_next   = ovf_reg;
    sat_next   = sat_reg;

    unique case (state_reg)
      IDLE: if (ue) state_next = ARM;
      ARM:  state_next = PEND;
      PEND: if (bus.intr_clr) state_next = ue ? ARM : IDLE;
      default: state_next = IDLE;
    endcase

    // Acknowledge clears overflow; a fresh overlapping event set after it wins
    if (bus.intr_clr) ovf_next = 1'b0;
    if (ue && ((state_reg == ARM) || ((state_reg == PEND) && !bus.intr_clr))) begin
      ovf_next = 1'b1;
    end

    // Counter clear dominates; cleared counters can never be at max
    if (bus.cnt_clr) begin
      sat_next = 1'b0;
    end else if (|at_max_vec) begin
      sat_next = 1'b1;
    end
  end

  // State and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ovf_reg   <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ovf_reg   <= ovf_next;
      sat_reg   <= sat_next;
    end
  end

  // Mask acts on the output only so unmasking during PEND shows at once
  assign bus.interrupt = (state_reg == PEND) & ~bus.intr_mask;
  assign bus.intr_ovf  = ovf_reg;
  assign bus.cnt_sat   = sat_reg;

endmodule

// File: tb/tb_add_err_intr_ctrl.sv
// Scoreboard bench for add_err_intr_ctrl with a 4-bit counter width.
module tb_add_err_intr_ctrl;
  import err_pkg::*;

  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // Expected {err_cnt, corr_cnt, interrupt, intr_ovf, cnt_sat}
  logic [10:0] exp_q [$];

  add_err_intr_ctrl_if #(.CNT_W(CW), .OP_W(3)) bus ();

  add_err_intr_ctrl #(.CNT_W(CW), .OP_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'(OP_ADD);
  localparam logic [2:0] SUB = 3'(OP_SUB);

  // Stimulus word {valid, op[2:0], uncorr, corr, mask, intr_clr, cnt_clr}
  function automatic logic [8:0] st(input logic v, input logic [2:0] op,
                                    input logic u, input logic c, input logic m,
                                    input logic ic, input logic cc);
    return {v, op, u, c, m, ic, cc};
  endfunction

  function automatic logic [10:0] ex(input int e, input int c, input logic i,
                                     input logic o, input logic s);
    return {4'(e), 4'(c), i, o, s};
  endfunction

  function automatic logic [10:0] obs();
    return {bus.err_cnt, bus.corr_cnt, bus.interrupt, bus.intr_ovf, bus.cnt_sat};
  endfunction

  task automatic apply(input logic [8:0] s);
    bus.req_valid  = s[8];
    bus.req_op     = s[7:5];
    bus.uncorr_err = s[4];
    bus.corr_err   = s[3];
    bus.intr_mask  = s[2];
    bus.intr_clr   = s[1];
    bus.cnt_clr    = s[0];
  endtask

  task automatic do_reset();
    apply('0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] got, want;
    rst_n = 1'b0;
    // An event during reset must not be counted
    apply(st(1, ADD, 1, 1, 0, 0, 0));
    exp_q.push_back(ex(0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL reset: got=%h want=%h", got, want);
    end else $display("reset: got=%h want=%h", got, want);
    apply('0);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_ue();
    logic [10:0] got, want;
    logic [8:0]  s_tab [5];
    logic [10:0] e_tab [5];
    s_tab = '{st(1, ADD, 1, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0),
              st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 0, 0)};
    e_tab = '{ex(1, 0, 0, 0, 0), ex(1, 0, 1, 0, 0), ex(1, 0, 1, 0, 0),
              ex(1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(s_tab[i]);
      exp_q.push_back(e_tab[i]);
      @(posedge clk);
      #1;
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL basic_ue[%0d]: got=%h want=%h", i, got, want);
      end else $display("basic_ue[%0d]: got=%h want=%h", i, got, want);
    end
  endtask

  task automatic test_mask();
    logic [10:0] got, want;
    logic [8:0]  s_tab [4];
    logic [10:0] e_tab [4];
    s_tab = '{st(1, ADD, 1, 0, 1, 0, 0), st(0, 0, 0, 0, 1, 0, 0),
              st(0, 0, 0, 0, 1, 0, 0), st(0, 0, 0, 0, 1, 0, 0)};
    e_tab = '{ex(1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(s_tab[i]);
      exp_q.push_back(e_tab[i]);
      @(posedge clk);
      #1;
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL mask[%0d]: got=%h want=%h", i, got, want);
      end else $display("mask[%0d]: got=%h want=%h", i, got, want);
    end
    // Unmask between edges: interrupt must rise without waiting for a clock
    bus.intr_mask = 1'b0;
    exp_q.push_back(ex(1, 0, 1, 0, 0));
    #1;
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL mask_unmask_now: got=%h want=%h", got, want);
    end else $display("mask_unmask_now: got=%h want=%h", got, want);
    apply(st(0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(ex(1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL mask_clr: got=%h want=%h", got, want);
    end else $display("mask_clr: got=%h want=%h", got, want);
  endtask

  task automatic test_filter();
    logic [10:0] got, want;
    logic [8:0]  s_tab [6];
    logic [10:0] e_tab [6];
    s_tab = '{st(1, SUB, 1, 0, 0, 0, 0), st(0, ADD, 1, 0, 0, 0, 0), st(1, ADD, 0, 1, 0, 0, 0),
              st(1, ADD, 1, 1, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0), st(1, SUB, 0, 1, 0, 0, 0)};
    e_tab = '{ex(0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0),
              ex(1, 1, 0, 0, 0), ex(1, 1, 1, 0, 0), ex(1, 1, 1, 0, 0)};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(s_tab[i]);
      exp_q.push_back(e_tab[i]);
      @(posedge clk);
      #1;
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL filter[%0d]: got=%h want=%h", i, got, want);
      end else $display("filter[%0d]: got=%h want=%h", i, got, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got, want;
    logic [8:0]  s_tab [9];
    logic [10:0] e_tab [9];
    s_tab = '{st(1, ADD, 1, 0, 0, 0, 0), st(1, ADD, 1, 0, 0, 0, 0), st(1, ADD, 1, 0, 0, 0, 0),
              st(1, ADD, 1, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 1, 0),
              st(1, ADD, 1, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 1, 0)};
    e_tab = '{ex(1, 0, 0, 0, 0), ex(2, 0, 1, 1, 0), ex(3, 0, 1, 1, 0),
              ex(4, 0, 0, 0, 0), ex(4, 0, 1, 0, 0), ex(4, 0, 0, 0, 0),
              ex(5, 0, 0, 0, 0), ex(5, 0, 1, 0, 0), ex(5, 0, 0, 0, 0)};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(s_tab[i]);
      exp_q.push_back(e_tab[i]);
      @(posedge clk);
      #1;
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL back_to_back[%0d]: got=%h want=%h", i, got, want);
      end else $display("back_to_back[%0d]: got=%h want=%h", i, got, want);
    end
  endtask

  task automatic test_saturation();
    logic [10:0] got, want;
    logic [8:0]  s_tab [6];
    logic [10:0] e_tab [6];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(st(1, ADD, 1, 0, 0, 0, 0));
      exp_q.push_back(ex((i + 1 > 15) ? 15 : i + 1, 0, i >= 1, i >= 1, i >= 14));
      @(posedge clk);
      #1;
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL sat_fill[%0d]: got=%h want=%h", i, got, want);
      end else $display("sat_fill[%0d]: got=%h want=%h", i, got, want);
    end
    // Event at max still interrupts; then clear with a coincident event
    s_tab = '{st(0, 0, 0, 0, 0, 1, 0), st(1, ADD, 1, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0),
              st(1, ADD, 1, 0, 0, 0, 1), st(0, 0, 0, 0, 0, 0, 1), st(0, 0, 0, 0, 0, 1, 0)};
    e_tab = '{ex(15, 0, 0, 0, 1), ex(15, 0, 0, 0, 1), ex(15, 0, 1, 0, 1),
              ex(1, 0, 1, 1, 0), ex(0, 0, 1, 1, 0), ex(0, 0, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      apply(s_tab[i]);
      exp_q.push_back(e_tab[i]);
      @(posedge clk);
      #1;
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL sat_tail[%0d]: got=%h want=%h", i, got, want);
      end else $display("sat_tail[%0d]: got=%h want=%h", i, got, want);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got, want;
    do_reset();
    apply(st(1, ADD, 1, 0, 0, 0, 0));
    exp_q.push_back(ex(1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL rst_mid_arm: got=%h want=%h", got, want);
    end else $display("rst_mid_arm: got=%h want=%h", got, want);
    // Asynchronous reset while in ARM: outputs drop before any clock edge
    apply('0);
    rst_n = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 0, 0));
    #1;
    got = obs(); want = exp_q.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL rst_mid_now: got=%h want=%h", got, want);
    end else $display("rst_mid_now: got=%h want=%h", got, want);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ex(0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      got = obs(); want = exp_q.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL rst_mid_after[%0d]: got=%h want=%h", i, got, want);
      end else $display("rst_mid_after[%0d]: got=%h want=%h", i, got, want);
    end
  endtask

  initial begin
    apply('0);
    rst_n = 1'b0;
    test_reset();
    test_basic_ue();
    test_mask();
    test_filter();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
